// File: rtl/regfile_sequencer.sv
// regfile_sequencer: multi-cycle command sequencer for the 8x16 register file.
// One command in flight; reads Rn/Rm, executes, writes Rd, keeps Z/N/V.
module regfile_sequencer #(
  parameter int WIDTH     = 16,
  parameter int IMM_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2:0]           opcode,
  input  logic [2:0]           rd,
  input  logic [2:0]           rn,
  input  logic [2:0]           rm,
  input  logic [IMM_WIDTH-1:0] imm8,
  input  logic [WIDTH-1:0]     rf_data_out,
  output logic [2:0]           rf_readnum,
  output logic [2:0]           rf_writenum,
  output logic                 rf_write,
  output logic [WIDTH-1:0]     rf_data_in,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 Z,
  output logic                 N,
  output logic                 V
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ_A,
    S_READ_B,
    S_EXEC,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [2:0] OP_MOVI = 3'd0;
  localparam logic [2:0] OP_MOV  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_CMP  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_MVN  = 3'd5;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [2:0]       rd_q, rd_d;
  logic [2:0]       rn_q, rn_d;
  logic [2:0]       rm_q, rm_d;
  logic [2:0]       rsel_q, rsel_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic             err_q, err_d;
  logic             z_q, z_d;
  logic             n_q, n_d;
  logic             v_q, v_d;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] andv;
  logic [WIDTH-1:0] mvnv;
  logic             sum_v;
  logic             diff_v;

  assign sum    = a_q + b_q;
  assign diff   = a_q - b_q;
  assign andv   = a_q & b_q;
  assign mvnv   = ~b_q;
  assign sum_v  = (a_q[WIDTH-1] == b_q[WIDTH-1])
                & (sum[WIDTH-1] != a_q[WIDTH-1]);
  assign diff_v = (a_q[WIDTH-1] != b_q[WIDTH-1])
                & (diff[WIDTH-1] != a_q[WIDTH-1]);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    rn_d    = rn_q;
    rm_d    = rm_q;
    rsel_d  = rsel_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    err_d   = err_q;
    z_d     = z_q;
    n_d     = n_q;
    v_d     = v_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = opcode;
          rd_d  = rd;
          rn_d  = rn;
          rm_d  = rm;
          err_d = 1'b0;
          unique case (1'b1)
            (opcode == OP_MOVI): begin
              c_d = {{(WIDTH-IMM_WIDTH){imm8[IMM_WIDTH-1]}}, imm8};
              state_d = S_WRITE;
            end
            (opcode == OP_MOV),
            (opcode == OP_MVN): state_d = S_READ_B;
            (opcode == OP_ADD),
            (opcode == OP_CMP),
            (opcode == OP_AND): state_d = S_READ_A;
            default: begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end
          endcase
        end
      end
      S_READ_A: begin
        a_d     = rf_data_out;
        rsel_d  = rn_q;
        state_d = S_READ_B;
      end
      S_READ_B: begin
        b_d     = rf_data_out;
        rsel_d  = rm_q;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_WRITE;
        unique case (1'b1)
          (op_q == OP_MOV): c_d = b_q;
          (op_q == OP_ADD): begin
            c_d = sum;
            z_d = (sum == '0);
            n_d = sum[WIDTH-1];
            v_d = sum_v;
          end
          (op_q == OP_AND): begin
            c_d = andv;
            z_d = (andv == '0);
            n_d = andv[WIDTH-1];
            v_d = 1'b0;
          end
          (op_q == OP_MVN): begin
            c_d = mvnv;
            z_d = (mvnv == '0);
            n_d = mvnv[WIDTH-1];
            v_d = 1'b0;
          end
          (op_q == OP_CMP): begin
            z_d     = (diff == '0);
            n_d     = diff[WIDTH-1];
            v_d     = diff_v;
            state_d = S_DONE;
          end
          default: state_d = S_DONE;
        endcase
      end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      rn_q    <= '0;
      rm_q    <= '0;
      rsel_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      err_q   <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      rn_q    <= rn_d;
      rm_q    <= rm_d;
      rsel_q  <= rsel_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      err_q   <= err_d;
      z_q     <= z_d;
      n_q     <= n_d;
      v_q     <= v_d;
    end
  end

  // read select holds its last value outside the two read states
  assign rf_readnum  = (state_q == S_READ_A) ? rn_q :
                       (state_q == S_READ_B) ? rm_q : rsel_q;
  assign rf_writenum = rd_q;
  assign rf_write    = (state_q == S_WRITE) & ~reset;
  assign rf_data_in  = c_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign err         = err_q;
  assign Z           = z_q;
  assign N           = n_q;
  assign V           = v_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// tb_regfile_sequencer: randomized and directed checks of regfile_sequencer
// against a command-level model with a register-file environment.
module tb_regfile_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  opcode, rd, rn, rm;
  logic [7:0]  imm8;
  logic [15:0] rf_data_out;
  logic [2:0]  rf_readnum, rf_writenum;
  logic        rf_write;
  logic [15:0] rf_data_in;
  logic        busy, done, err, Z, N, V;

  always #5 clk = ~clk;

  regfile_sequencer dut (
    .clk(clk), .reset(reset), .start(start),
    .opcode(opcode), .rd(rd), .rn(rn), .rm(rm), .imm8(imm8),
    .rf_data_out(rf_data_out), .rf_readnum(rf_readnum),
    .rf_writenum(rf_writenum), .rf_write(rf_write),
    .rf_data_in(rf_data_in), .busy(busy), .done(done), .err(err),
    .Z(Z), .N(N), .V(V)
  );

  logic [15:0] rf [8] = '{default: 16'h0};
  logic        pl_en = 1'b0;
  logic [2:0]  pl_idx = 3'd0;
  logic [15:0] pl_val = 16'h0;

  assign rf_data_out = rf[rf_readnum];

  always @(posedge clk) begin
    if (rf_write) rf[rf_writenum] <= rf_data_in;
    else if (pl_en) rf[pl_idx] <= pl_val;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int          L;
    bit          wr, fl, two, one;
    logic [2:0]  rd, rn, rm;
    logic [15:0] res;
    bit          z, n, v;
  } exp_t;

  logic [15:0] mref [8] = '{default: 16'h0};
  exp_t m;
  bit   active = 0;
  int   k = 0;
  bit   zf = 0, nf = 0, vf = 0, errm = 0;
  bit   checking = 0;

  function automatic exp_t predict(input logic [2:0] op, d, n, mm,
                                   input logic [7:0] im);
    exp_t e;
    logic [15:0] a, b;
    int r;
    a = mref[n];
    b = mref[mm];
    e = '{default: 0};
    e.rd = d; e.rn = n; e.rm = mm; e.wr = 1;
    case (op)
      3'd0: begin e.L = 2; e.res = 16'($signed(im)); end
      3'd1: begin e.L = 4; e.one = 1; e.res = b; end
      3'd2: begin
        e.L = 5; e.two = 1; e.fl = 1; e.res = a + b;
        r = int'($signed(a)) + int'($signed(b));
        e.v = (r > 32767) || (r < -32768);
      end
      3'd3: begin
        e.L = 4; e.two = 1; e.fl = 1; e.wr = 0; e.res = a - b;
        r = int'($signed(a)) - int'($signed(b));
        e.v = (r > 32767) || (r < -32768);
      end
      3'd4: begin e.L = 5; e.two = 1; e.fl = 1; e.res = a & b; end
      3'd5: begin e.L = 4; e.one = 1; e.fl = 1; e.res = ~b; end
      default: begin e.L = 1; e.wr = 0; end
    endcase
    if (e.fl) begin
      e.z = (e.res == 16'h0);
      e.n = e.res[15];
    end
    return e;
  endfunction

  // command-level model: timeline from latency, state applied at commit
  always @(posedge clk) begin
    if (reset) begin
      active <= 0; k <= 0;
      zf <= 0; nf <= 0; vf <= 0; errm <= 0;
    end else if (!active) begin
      if (pl_en) mref[pl_idx] <= pl_val;
      if (start) begin
        m      <= predict(opcode, rd, rn, rm, imm8);
        errm   <= (opcode[2:1] == 2'b11);
        active <= 1;
        k      <= 1;
      end
    end else begin
      if (k == m.L - 1) begin
        if (m.wr) mref[m.rd] <= m.res;
        if (m.fl) begin zf <= m.z; nf <= m.n; vf <= m.v; end
      end
      if (k == m.L) active <= 0;
      k <= k + 1;
    end
  end

  always @(negedge clk) begin
    bit eb, ed, ew;
    #2;
    if (checking) begin
      eb = active;
      ed = active && (k == m.L);
      ew = active && m.wr && (k == m.L - 1) && !reset;
      chk("busy", 32'(busy), 32'(eb));
      chk("done", 32'(done), 32'(ed));
      chk("rf_write", 32'(rf_write), 32'(ew));
      if (ew) begin
        chk("writenum", 32'(rf_writenum), 32'(m.rd));
        chk("data_in", 32'(rf_data_in), 32'(m.res));
      end
      if (active && k == 1 && (m.two || m.one))
        chk("readnum1", 32'(rf_readnum), 32'(m.two ? m.rn : m.rm));
      if (active && k == 2 && m.two)
        chk("readnum2", 32'(rf_readnum), 32'(m.rm));
      if (!reset) chk("err", 32'(err), 32'(errm));
      if (!reset && (!active || k == m.L)) begin
        chk("Z", 32'(Z), 32'(zf));
        chk("N", 32'(N), 32'(nf));
        chk("V", 32'(V), 32'(vf));
      end
    end
  end

  task automatic setreg(input logic [2:0] i, input logic [15:0] v);
    @(negedge clk);
    pl_en = 1; pl_idx = i; pl_val = v;
    @(negedge clk);
    pl_en = 0;
  endtask

  task automatic issue(input logic [2:0] op, d, n, mm,
                       input logic [7:0] im, input int pulse_at,
                       output int lat);
    @(negedge clk);
    opcode = op; rd = d; rn = n; rm = mm; imm8 = im; start = 1;
    @(negedge clk);
    start = 0; lat = 1;
    opcode = 3'($urandom); rd = 3'($urandom);
    rn = 3'($urandom); rm = 3'($urandom); imm8 = 8'($urandom);
    while (!done && lat < 20) begin
      if (lat == pulse_at) start = 1;
      @(negedge clk);
      start = 0;
      lat++;
    end
    start = 0;
    if (!done) chk("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic check_regs();
    for (int i = 0; i < 8; i++) chk("regfile", 32'(rf[i]), 32'(mref[i]));
  endtask

  initial begin
    int lat;
    reset = 1; start = 0;
    opcode = 0; rd = 0; rn = 0; rm = 0; imm8 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_write", 32'(rf_write), 32'd0);
    chk("rst_readnum", 32'(rf_readnum), 32'd0);
    chk("rst_writenum", 32'(rf_writenum), 32'd0);
    chk("rst_data_in", 32'(rf_data_in), 32'd0);
    chk("rst_flags", 32'({Z, N, V}), 32'd0);
    reset = 0;
    checking = 1;

    issue(3'd0, 3'd3, 3'd0, 3'd0, 8'hFF, 0, lat);
    chk("movi_lat", lat, 2);
    chk("movi_R3", 32'(rf[3]), 32'h0000FFFF);

    setreg(3'd1, 16'h7FFF);
    setreg(3'd2, 16'h0001);
    issue(3'd2, 3'd0, 3'd1, 3'd2, 8'h00, 0, lat);
    chk("add_lat", lat, 5);
    chk("add_R0", 32'(rf[0]), 32'h00008000);
    chk("add_ZNV", 32'({Z, N, V}), 32'b011);

    setreg(3'd4, 16'h0005);
    issue(3'd3, 3'd7, 3'd4, 3'd4, 8'h00, 0, lat);
    chk("cmp_lat", lat, 4);
    chk("cmp_ZNV", 32'({Z, N, V}), 32'b100);

    setreg(3'd5, 16'h00F0);
    issue(3'd5, 3'd5, 3'd0, 3'd5, 8'h00, 2, lat);
    chk("mvn_lat", lat, 4);
    chk("mvn_R5", 32'(rf[5]), 32'h0000FF0F);

    issue(3'd6, 3'd2, 3'd0, 3'd0, 8'h00, 0, lat);
    chk("ill_lat", lat, 1);
    chk("ill_err", 32'(err), 32'd1);
    issue(3'd1, 3'd6, 3'd0, 3'd5, 8'h00, 0, lat);
    chk("mov_lat", lat, 4);
    chk("err_clr", 32'(err), 32'd0);
    chk("mov_R6", 32'(rf[6]), 32'h0000FF0F);

    setreg(3'd1, 16'h1234);
    issue(3'd2, 3'd1, 3'd1, 3'd1, 8'h00, 0, lat);
    chk("dbl_R1", 32'(rf[1]), 32'h00002468);
    check_regs();

    setreg(3'd0, 16'hAAAA);
    @(negedge clk);
    opcode = 3'd2; rd = 3'd0; rn = 3'd1; rm = 3'd2; start = 1;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    chk("pre_rst_write", 32'(rf_write), 32'd1);
    reset = 1;
    #1;
    chk("rst_wr_suppr", 32'(rf_write), 32'd0);
    @(negedge clk);
    chk("post_rst_outs",
        32'({busy, done, err, rf_write, Z, N, V}), 32'd0);
    chk("post_rst_data", 32'(rf_data_in), 32'd0);
    chk("post_rst_sel", 32'({rf_readnum, rf_writenum}), 32'd0);
    chk("post_rst_R0", 32'(rf[0]), 32'h0000AAAA);
    reset = 0;

    for (int i = 0; i < 8; i++) setreg(3'(i), 16'($urandom));
    for (int t = 0; t < 150; t++) begin
      int pa;
      pa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      issue(3'($urandom_range(0, 7)), 3'($urandom), 3'($urandom),
            3'($urandom), 8'($urandom), pa, lat);
      check_regs();
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
